// File: rtl/ws2811_frame_ctrl.sv
// ws2811_frame_ctrl
//   Double-buffered pixel frame store and sequencer for the ws2811 strip driver.
//   The host fills the back bank and pulses commit. The banks swap only when the
//   driver begins a new frame, so a frame is never shown half old and half new.
//   Each driver data request is answered one cycle later with the next pixel,
//   scaled by the global brightness.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   wr_valid/wr_ready    host pixel write handshake (ready low while a swap is pending)
//   wr_addr, wr_data     pixel index and {R,G,B}; indices >= NUM_LEDS are dropped
//   commit               pulse: back bank complete, request a swap
//   swap_pending         commit registered, swap not yet taken
//   brightness, blank    global scale (255 = full) and force-black
//   drv_data_request     driver asks for the next pixel
//   drv_address          driver pixel address; 0 marks the first pixel of a frame
//   red, green, blue     scaled pixel, valid one cycle after the request, held after
//   frame_start          one-cycle pulse per frame start
//   frame_count          frames started, wraps at 16 bits
module ws2811_frame_ctrl #(
  parameter int NUM_LEDS = 49,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              commit,
  output logic              swap_pending,
  input  logic [7:0]        brightness,
  input  logic              blank,
  input  logic              drv_data_request,
  input  logic [ADDR_W-1:0] drv_address,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              frame_start,
  output logic [15:0]       frame_count
);

  localparam int                IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [ADDR_W:0]   LED_LIMIT = (ADDR_W + 1)'(NUM_LEDS);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);

  logic              front_sel_reg, front_sel_next;
  logic [ADDR_W-1:0] rd_idx_reg, rd_idx_next;
  logic              swap_pending_reg, swap_pending_next;
  logic [23:0]       rgb_reg, rgb_next;
  logic              frame_start_reg, frame_start_next;
  logic [15:0]       frame_count_reg, frame_count_next;

  logic              start_req;
  logic [ADDR_W-1:0] idx_used;
  logic              read_sel;
  logic              back_sel;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_addr;
  logic [23:0]       rd_word [2];
  logic [23:0]       pixel;
  logic [8:0]        bright_p1;
  logic [23:0]       scaled;

  assign start_req = drv_data_request && (drv_address == '0);
  assign idx_used  = start_req ? '0 : rd_idx_reg;
  // A frame-start read already sees the bank that becomes front on this edge.
  assign read_sel  = front_sel_reg ^ (start_req & swap_pending_reg);
  assign back_sel  = ~front_sel_reg;
  // While a swap is pending the back bank is frozen; writes beyond the strip are
  // accepted but dropped.
  assign wr_en     = wr_valid && !swap_pending_reg && ({1'b0, wr_addr} < LED_LIMIT);
  assign wr_idx    = wr_addr[IDX_W-1:0];
  assign rd_addr   = idx_used[IDX_W-1:0];

  genvar gi;

  // Two banks, asynchronous read so the pixel is ready in the request cycle.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [23:0] mem [NUM_LEDS];
      always_ff @(posedge clk) begin
        if (wr_en && (back_sel == 1'(gi))) begin
          mem[wr_idx] <= wr_data;
        end
      end
      assign rd_word[gi] = mem[rd_addr];
    end
  endgenerate

  assign pixel     = rd_word[read_sel];
  assign bright_p1 = {1'b0, brightness} + 9'd1;

  // Per-channel (c * (brightness+1)) >> 8; brightness 255 is an exact passthrough.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_scale
      logic [15:0] product;
      assign product             = {8'd0, pixel[gi*8 +: 8]} * {7'd0, bright_p1};
      assign scaled[gi*8 +: 8]   = 8'(product >> 8);
    end
  endgenerate

  always_comb begin
    front_sel_next    = front_sel_reg;
    rd_idx_next       = rd_idx_reg;
    rgb_next          = rgb_reg;
    frame_start_next  = start_req;
    frame_count_next  = frame_count_reg + (start_req ? 16'd1 : 16'd0);
    swap_pending_next = swap_pending_reg;

    if (drv_data_request) begin
      front_sel_next = read_sel;
      rd_idx_next    = (idx_used == LAST_IDX) ? '0 : idx_used + ADDR_W'(1);
      rgb_next       = blank ? 24'd0 : scaled;
    end

    // A pending swap is consumed only by a frame start; a commit arriving in
    // that same cycle is ignored because the request was already pending.
    if (swap_pending_reg) begin
      swap_pending_next = !start_req;
    end else begin
      swap_pending_next = commit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel_reg    <= 1'b0;
      rd_idx_reg       <= '0;
      swap_pending_reg <= 1'b0;
      rgb_reg          <= 24'd0;
      frame_start_reg  <= 1'b0;
      frame_count_reg  <= 16'd0;
    end else begin
      front_sel_reg    <= front_sel_next;
      rd_idx_reg       <= rd_idx_next;
      swap_pending_reg <= swap_pending_next;
      rgb_reg          <= rgb_next;
      frame_start_reg  <= frame_start_next;
      frame_count_reg  <= frame_count_next;
    end
  end

  assign wr_ready     = ~swap_pending_reg;
  assign swap_pending = swap_pending_reg;
  assign red          = rgb_reg[23:16];
  assign green        = rgb_reg[15:8];
  assign blue         = rgb_reg[7:0];
  assign frame_start  = frame_start_reg;
  assign frame_count  = frame_count_reg;

endmodule
